// File: rtl/game_pkg.sv
// game_pkg: shared types and codes for the light-cycle game sequencer.
//   game_state_t : IDLE / COUNTDOWN / RUN / OVER phase encoding
//   turn_req_t   : contents of one player's pending-turn buffer
//   SEL_*        : selected_player codes driven to the direction-update logic
//   WIN_*        : winner codes
//   next_req()   : pending-buffer update rule for one player
package game_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      RUN       = 2'd2,
      OVER      = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } turn_req_t;

   localparam logic [1:0] SEL_RESET = 2'b00;
   localparam logic [1:0] SEL_P1    = 2'b01;
   localparam logic [1:0] SEL_HOLD  = 2'b10;
   localparam logic [1:0] SEL_P2    = 2'b11;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_P1    = 2'b01;
   localparam logic [1:0] WIN_P2    = 2'b10;
   localparam logic [1:0] WIN_DRAW  = 2'b11;

   // A single click overwrites the buffer (latest wins); a simultaneous
   // left+right is contradictory and leaves the buffer alone. A new click
   // takes priority over the clear performed when the slot is served.
   function automatic turn_req_t next_req(input turn_req_t cur,
                                          input logic      left,
                                          input logic      right,
                                          input logic      served);
      if (left ^ right)
         return left ? LEFT : RIGHT;
      if (served)
         return NONE;
      return cur;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: control bundle between the game sequencer and its
// surroundings (start button, player clicks, collision flags in; slot
// selection, turn pulses, movement tick and status out).
//   master : the sequencer side (drives selection/turns/tick/status)
//   slave  : the environment side (drives start/clicks/crash flags)
interface game_sequencer_if;
   import game_pkg::*;

   logic        start;
   logic        p1_left;
   logic        p1_right;
   logic        p2_left;
   logic        p2_right;
   logic        crash_1;
   logic        crash_2;

   logic [1:0]  selected_player;
   logic        turn_left;
   logic        turn_right;
   logic        move_tick;
   game_state_t state;
   logic [1:0]  winner;
   logic [1:0]  countdown;

   modport master (
      input  start, p1_left, p1_right, p2_left, p2_right, crash_1, crash_2,
      output selected_player, turn_left, turn_right, move_tick, state,
             winner, countdown
   );

   modport slave (
      output start, p1_left, p1_right, p2_left, p2_right, crash_1, crash_2,
      input  selected_player, turn_left, turn_right, move_tick, state,
             winner, countdown
   );

endinterface

// File: rtl/game_sequencer_tick_phase_timer.sv
// tick_phase_timer: movement-period phase counter plus the countdown
// second sub-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   run_en     : count (COUNTDOWN or RUN); when low both counters sit at 0
//   clr        : synchronous clear of both counters
//   slot1      : ph == 0  (P1 service slot)
//   slot2      : ph == 1  (P2 service slot)
//   tick       : ph == 2  (movement tick decision)
//   sample     : ph == 4  (collision sample decision)
//   sec_done   : last cycle of a countdown second
module tick_phase_timer #(
   parameter int TICK_CYCLES   = 8_125_000,
   parameter int TICKS_PER_SEC = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_en,
   input  logic clr,
   output logic slot1,
   output logic slot2,
   output logic tick,
   output logic sample,
   output logic sec_done
);

   localparam int PH_W  = $clog2(TICK_CYCLES);
   localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TICK_CYCLES - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

   logic [PH_W-1:0]  ph;
   logic [SUB_W-1:0] sub;
   logic             ph_wrap;

   assign ph_wrap = (ph == PH_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph  <= '0;
         sub <= '0;
      end else if (clr || !run_en) begin
         ph  <= '0;
         sub <= '0;
      end else if (ph_wrap) begin
         ph  <= '0;
         sub <= (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
      end else begin
         ph  <= ph + PH_W'(1);
      end
   end

   assign slot1    = (ph == PH_W'(0));
   assign slot2    = (ph == PH_W'(1));
   assign tick     = (ph == PH_W'(2));
   assign sample   = (ph == PH_W'(4));
   // Gated by run_en so a stale phase never reads as a finished second.
   assign sec_done = run_en && ph_wrap && (sub == SUB_LAST);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the two-player light-cycle game.
// Steps IDLE -> COUNTDOWN -> RUN -> OVER, buffers one pending turn per
// player and serves them in alternating slots, emits the movement tick and
// latches the winner from the collision flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : game_sequencer_if.master
//                in : start, p1_left/right, p2_left/right, crash_1/2
//                out: selected_player, turn_left/right, move_tick, state,
//                     winner, countdown (all registered)
module game_sequencer
   import game_pkg::*;
#(
   parameter int TICK_CYCLES   = 8_125_000,
   parameter int TICKS_PER_SEC = 8,
   parameter int COUNT_SECONDS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   game_sequencer_if.master    bus
);

   localparam logic [1:0] CD_LOAD = 2'(COUNT_SECONDS);

   game_state_t state_q;
   turn_req_t   pend1_q;
   turn_req_t   pend2_q;
   logic [1:0]  sel_q;
   logic        tl_q;
   logic        tr_q;
   logic        mt_q;
   logic [1:0]  win_q;
   logic [1:0]  cd_q;

   logic slot1, slot2, tick, sample, sec_done;
   logic enter_cd, crash_hit, run_en;

   assign enter_cd  = bus.start && ((state_q == IDLE) || (state_q == OVER));
   assign crash_hit = (state_q == RUN) && sample && (bus.crash_1 || bus.crash_2);
   assign run_en    = (state_q == COUNTDOWN) || (state_q == RUN);

   // Clearing on the crash as well keeps ph at 0 from the first OVER cycle.
   tick_phase_timer #(
      .TICK_CYCLES   (TICK_CYCLES),
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_en   (run_en),
      .clr      (enter_cd || crash_hit),
      .slot1    (slot1),
      .slot2    (slot2),
      .tick     (tick),
      .sample   (sample),
      .sec_done (sec_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend1_q <= NONE;
         pend2_q <= NONE;
         sel_q   <= SEL_RESET;
         tl_q    <= 1'b0;
         tr_q    <= 1'b0;
         mt_q    <= 1'b0;
         win_q   <= WIN_NONE;
         cd_q    <= 2'd0;
      end else begin
         sel_q <= SEL_RESET;
         tl_q  <= 1'b0;
         tr_q  <= 1'b0;
         mt_q  <= 1'b0;
         case (state_q)
            IDLE, OVER: begin
               // Clicks are not buffered here, so a click coincident with
               // start is simply lost.
               if (enter_cd) begin
                  state_q <= COUNTDOWN;
                  pend1_q <= NONE;
                  pend2_q <= NONE;
                  win_q   <= WIN_NONE;
                  cd_q    <= CD_LOAD;
               end
            end
            COUNTDOWN: begin
               if (sec_done) begin
                  cd_q <= cd_q - 2'd1;
                  if (cd_q == 2'd1)
                     state_q <= RUN;
               end
            end
            RUN: begin
               pend1_q <= next_req(pend1_q, bus.p1_left, bus.p1_right, slot1);
               pend2_q <= next_req(pend2_q, bus.p2_left, bus.p2_right, slot2);
               if (crash_hit) begin
                  state_q <= OVER;
                  if (bus.crash_1 && bus.crash_2)
                     win_q <= WIN_DRAW;
                  else if (bus.crash_1)
                     win_q <= WIN_P2;
                  else
                     win_q <= WIN_P1;
               end else begin
                  if (slot1) begin
                     sel_q <= SEL_P1;
                     tl_q  <= (pend1_q == LEFT);
                     tr_q  <= (pend1_q == RIGHT);
                  end else if (slot2) begin
                     sel_q <= SEL_P2;
                     tl_q  <= (pend2_q == LEFT);
                     tr_q  <= (pend2_q == RIGHT);
                  end else begin
                     sel_q <= SEL_HOLD;
                  end
                  mt_q <= tick;
               end
            end
         endcase
      end
   end

   assign bus.state           = state_q;
   assign bus.selected_player = sel_q;
   assign bus.turn_left       = tl_q;
   assign bus.turn_right      = tr_q;
   assign bus.move_tick       = mt_q;
   assign bus.winner          = win_q;
   assign bus.countdown       = cd_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with a time-based
// behavioural model compared every cycle plus literal spot checks.
module tb_game_sequencer;
   import game_pkg::*;

   localparam int TC  = 16;
   localparam int TPS = 2;
   localparam int CS  = 3;
   localparam int SEC_LEN = TPS * TC;
   localparam int CD_LEN  = CS * SEC_LEN;

   logic clk;
   logic rst_n;
   game_sequencer_if gif();

   game_sequencer #(
      .TICK_CYCLES   (TC),
      .TICKS_PER_SEC (TPS),
      .COUNT_SECONDS (CS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (gif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit armed = 0;
   int mt_seen = 0;
   logic [3:0] tlog[$];

   // ---------------- behavioural model ----------------
   // m_t counts cycles elapsed since the current counting phase began.
   int         m_state;
   int         m_t;
   int         pend1, pend2;
   logic [1:0] e_sel, e_win, e_cd;
   logic       e_tl, e_tr, e_mt;

   always @(posedge clk or negedge rst_n) begin : model_blk
      int         phm;
      int         n1, n2;
      logic [1:0] s;
      logic       l, r, m;
      if (!rst_n) begin
         m_state <= 0; m_t <= 0; pend1 <= 0; pend2 <= 0;
         e_sel <= 2'b00; e_tl <= 1'b0; e_tr <= 1'b0; e_mt <= 1'b0;
         e_win <= 2'b00; e_cd <= 2'd0;
      end else begin
         s = 2'b00; l = 1'b0; r = 1'b0; m = 1'b0;
         case (m_state)
            0, 3: if (gif.start) begin
               m_state <= 1; m_t <= 0; e_win <= 2'b00; e_cd <= 2'(CS);
               pend1 <= 0; pend2 <= 0;
            end
            1: if (m_t + 1 == CD_LEN) begin
               m_state <= 2; m_t <= 0; e_cd <= 2'd0;
            end else begin
               m_t  <= m_t + 1;
               e_cd <= 2'(CS - (m_t + 1) / SEC_LEN);
            end
            default: begin
               phm = m_t % TC;
               n1 = pend1; n2 = pend2;
               if (phm == 4 && (gif.crash_1 || gif.crash_2)) begin
                  m_state <= 3; m_t <= 0;
                  e_win <= (gif.crash_1 && gif.crash_2) ? 2'b11 :
                           gif.crash_1 ? 2'b10 : 2'b01;
               end else begin
                  m_t <= m_t + 1;
                  if (phm == 0) begin
                     s = 2'b01; l = (pend1 == 1); r = (pend1 == 2); n1 = 0;
                  end else if (phm == 1) begin
                     s = 2'b11; l = (pend2 == 1); r = (pend2 == 2); n2 = 0;
                  end else begin
                     s = 2'b10;
                  end
                  m = (phm == 2);
               end
               if (gif.p1_left != gif.p1_right) n1 = gif.p1_left ? 1 : 2;
               if (gif.p2_left != gif.p2_right) n2 = gif.p2_left ? 1 : 2;
               pend1 <= n1; pend2 <= n2;
            end
         endcase
         e_sel <= s; e_tl <= l; e_tr <= r; e_mt <= m;
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [10:0] got, want;
      if (armed) begin
         got  = {2'(gif.state), gif.selected_player, gif.turn_left, gif.turn_right,
                 gif.move_tick, gif.winner, gif.countdown};
         want = {2'(m_state), e_sel, e_tl, e_tr, e_mt, e_win, e_cd};
         tests = tests + 1;
         if (got !== want) begin
            fails = fails + 1;
            $display("FAIL model cycle %0d: got st/sel/tl/tr/mt/win/cd=%b required %b",
                     cyc, got, want);
         end
         if (gif.turn_left || gif.turn_right)
            tlog.push_back({gif.selected_player, gif.turn_left, gif.turn_right});
         if (gif.move_tick) mt_seen = mt_seen + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int req);
      tests = tests + 1;
      if (act !== req) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   function automatic int log_at(input int i);
      if (i < tlog.size()) return int'(tlog[i]);
      return -1;
   endfunction

   task automatic wait_ph(input int k, input int bound);
      bit hit = 0;
      for (int i = 0; i < bound && !hit; i++) begin
         @(posedge clk); #1;
         if (m_state == 2 && (m_t % TC) == k) hit = 1;
      end
      if (!hit) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL wait_ph: phase %0d not reached within %0d cycles", k, bound);
      end
   endtask

   // c = {p1_left, p1_right, p2_left, p2_right}
   task automatic pulse(input logic [3:0] c, input logic st);
      gif.p1_left = c[3]; gif.p1_right = c[2];
      gif.p2_left = c[1]; gif.p2_right = c[0];
      gif.start = st;
      @(posedge clk); #1;
      gif.p1_left = 1'b0; gif.p1_right = 1'b0;
      gif.p2_left = 1'b0; gif.p2_right = 1'b0;
      gif.start = 1'b0;
   endtask

   task automatic crash_at_sample(input logic c1, input logic c2);
      wait_ph(3, 40);
      gif.crash_1 = c1; gif.crash_2 = c2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      gif.crash_1 = 1'b0; gif.crash_2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      gif.start = 1'b0; gif.p1_left = 1'b0; gif.p1_right = 1'b0;
      gif.p2_left = 1'b0; gif.p2_right = 1'b0;
      gif.crash_1 = 1'b0; gif.crash_2 = 1'b0;
      repeat (3) @(posedge clk);
      #1 armed = 1;
      rst_n = 1'b1;

      // Reset values and idle
      check("reset_state", int'(gif.state), 0);
      check("reset_sel", int'(gif.selected_player), 0);
      repeat (100) @(posedge clk);
      #1;
      check("idle_state", int'(gif.state), 0);
      check("idle_no_move_tick", mt_seen, 0);

      // Game 1: countdown timing and first move tick
      pulse(4'b0000, 1'b1);
      check("cd_load", int'(gif.countdown), 3);
      check("cd_state", int'(gif.state), 1);
      repeat (32) @(posedge clk);
      #1 check("cd_after_1s", int'(gif.countdown), 2);
      repeat (32) @(posedge clk);
      #1 check("cd_after_2s", int'(gif.countdown), 1);
      repeat (32) @(posedge clk);
      #1;
      check("run_entered", int'(gif.state), 2);
      check("cd_zero_in_run", int'(gif.countdown), 0);
      repeat (2) @(posedge clk);
      #1 check("no_tick_at_98", int'(gif.move_tick), 0);
      @(posedge clk);
      #1 check("first_tick_at_99", int'(gif.move_tick), 1);

      // Both players, different phases of one period
      tlog.delete();
      wait_ph(7, 40);
      pulse(4'b0100, 1'b0);
      wait_ph(9, 40);
      pulse(4'b0010, 1'b0);
      wait_ph(3, 40);
      check("two_turns_count", tlog.size(), 2);
      check("p1_right_served", log_at(0), 4'b0101);
      check("p2_left_served", log_at(1), 4'b1110);

      // Latest click wins
      tlog.delete();
      wait_ph(5, 40);
      pulse(4'b1000, 1'b0);
      wait_ph(8, 40);
      pulse(4'b0100, 1'b0);
      wait_ph(3, 40);
      check("latest_wins_count", tlog.size(), 1);
      check("latest_wins_right", log_at(0), 4'b0101);

      // Left+right together is ignored
      tlog.delete();
      wait_ph(6, 40);
      pulse(4'b1100, 1'b0);
      wait_ph(3, 40);
      check("both_dirs_ignored", tlog.size(), 0);

      // Click in own slot is deferred one tick
      tlog.delete();
      wait_ph(0, 40);
      pulse(4'b1000, 1'b0);
      wait_ph(3, 40);
      check("slot_click_not_served", tlog.size(), 0);
      wait_ph(3, 40);
      check("slot_click_next_tick", log_at(0), 4'b0110);

      // Draw
      crash_at_sample(1'b1, 1'b1);
      check("draw_state", int'(gif.state), 3);
      check("draw_winner", int'(gif.winner), 3);
      check("draw_sel", int'(gif.selected_player), 0);
      repeat (5) @(posedge clk);
      #1 check("winner_held", int'(gif.winner), 3);

      // Game 2: start with a click in OVER, ignored starts, P1 crashes
      tlog.delete();
      pulse(4'b1010, 1'b1);
      check("restart_winner_clear", int'(gif.winner), 0);
      repeat (10) @(posedge clk);
      #1 pulse(4'b0000, 1'b1);
      check("start_ignored_cd", int'(gif.state), 1);
      wait_ph(5, 200);
      pulse(4'b0000, 1'b1);
      check("start_ignored_run", int'(gif.state), 2);
      check("over_click_dropped", tlog.size(), 0);
      crash_at_sample(1'b1, 1'b0);
      check("p2_wins_state", int'(gif.state), 3);
      check("p2_wins_code", int'(gif.winner), 2);

      // Game 3: reset mid-run with a pending turn
      pulse(4'b0000, 1'b1);
      wait_ph(5, 200);
      tlog.delete();
      pulse(4'b0100, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("rst_state", int'(gif.state), 0);
      check("rst_sel", int'(gif.selected_player), 0);
      check("rst_pulses", int'({gif.turn_left, gif.turn_right, gif.move_tick}), 0);
      check("rst_winner", int'(gif.winner), 0);
      check("rst_countdown", int'(gif.countdown), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("no_turn_replay", tlog.size(), 0);
      check("idle_after_reset", int'(gif.state), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
